// File: rtl/point_dac_pacer_pkg.sv
// Shared types and constants for the point DAC pacer.
// Holds the pacer state encoding and the beam park position.
package point_dac_pacer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } pacer_state_t;

  localparam logic [7:0] DAC_CENTER = 8'h80;

endpackage

// File: rtl/point_dac_pacer_fifo.sv
// Synchronous point FIFO, 16-bit {x,y} entries, depth 2**ADDR_W; push/pop take effect at the edge.
// Pushes when full and pops when empty are ignored; the read data is the head entry.
module point_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [15:0]       i_dat,
  input  logic              i_pop,
  output logic [15:0]       o_dat,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == (ADDR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dat   = r_mem[r_rd_ptr];

  // Full blocks a push even when the same cycle pops.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/point_dac_pacer.sv
// Buffers drawn points and presents each on the DAC for max(dwell,1) cycles; 1-cycle push-to-DAC latency.
// No backpressure: points arriving while the FIFO is full are dropped and flagged in sticky overflow.
module point_dac_pacer
  import point_dac_pacer_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic [7:0]         xin,
  input  logic [7:0]         yin,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               clr_ovf,
  output logic [7:0]         dac_x,
  output logic [7:0]         dac_y,
  output logic               dac_ld,
  output logic               full,
  output logic               empty,
  output logic [ADDR_W:0]    count,
  output logic               overflow
);

  pacer_state_t       r_state;
  logic [DWELL_W-1:0] r_hold_cnt;
  logic [7:0]         r_dac_x;
  logic [7:0]         r_dac_y;
  logic               r_dac_ld;
  logic               r_overflow;
  logic [15:0]        w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_load;
  logic               w_drop;

  point_fifo #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wr),
    .i_dat   ({xin, yin}),
    .i_pop   (w_load),
    .o_dat   (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Loads look only at the registered empty flag, so a same-cycle push waits one cycle.
  assign w_load = ~w_empty & ((r_state == IDLE) | (r_hold_cnt == '0));
  assign w_drop = wr & w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_dac_x    <= DAC_CENTER;
      r_dac_y    <= DAC_CENTER;
      r_dac_ld   <= 1'b0;
    end else begin
      r_dac_ld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_dac_x    <= w_head[15:8];
            r_dac_y    <= w_head[7:0];
            r_dac_ld   <= 1'b1;
            r_hold_cnt <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - DWELL_W'(1);
          end else if (w_load) begin
            r_dac_x    <= w_head[15:8];
            r_dac_y    <= w_head[7:0];
            r_dac_ld   <= 1'b1;
            r_hold_cnt <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign dac_x    = r_dac_x;
  assign dac_y    = r_dac_y;
  assign dac_ld   = r_dac_ld;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_point_dac_pacer.sv
// Randomized and directed stimulus against a queue-based model of the pacer; a monitor scores DAC loads and status.
module tb_point_dac_pacer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] xin;
  logic [7:0] yin;
  logic [7:0] dwell;
  logic       clr_ovf;
  logic [7:0] dac_x;
  logic [7:0] dac_y;
  logic       dac_ld;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;

  point_dac_pacer #(.ADDR_W(4), .DWELL_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .xin      (xin),
    .yin      (yin),
    .dwell    (dwell),
    .clr_ovf  (clr_ovf),
    .dac_x    (dac_x),
    .dac_y    (dac_y),
    .dac_ld   (dac_ld),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] pt;
  } exp_t;

  // Model: buffered points, cycles left on the current point, sticky flag, displayed point.
  logic [15:0] m_q[$];
  int          m_left;
  bit          m_ovf;
  logic [15:0] m_cur;
  exp_t        exp_q[$];
  int          cyc;
  bit          en;
  int          vectors;
  int          errors;

  task automatic step(input bit w, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] dw, input bit clr, input bit r);
    bit   can_load;
    bit   was_full;
    exp_t e;
    @(negedge clk);
    wr = w; xin = x; yin = y; dwell = dw; clr_ovf = clr; rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
      m_cur  = 16'h8080;
    end else begin
      can_load = (m_q.size() != 0) && (m_left <= 1);
      was_full = (m_q.size() == 16);
      if (can_load) begin
        m_cur  = m_q.pop_front();
        m_left = (dw == 0) ? 1 : int'(dw);
        e.cyc  = cyc;
        e.pt   = m_cur;
        exp_q.push_back(e);
      end else if (m_left > 0) begin
        m_left--;
      end
      if (w) begin
        if (was_full) m_ovf = 1'b1;
        else m_q.push_back({x, y});
      end
      if (clr && !(w && was_full)) m_ovf = 1'b0;
    end
  endtask

  task automatic idle(input int n, input logic [7:0] dw);
    for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00, dw, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (en) begin
      vectors++;
      if (dac_ld) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ld cyc=%0d got (%02h,%02h) expected no load", cyc, dac_x, dac_y);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || {dac_x, dac_y} != e.pt) begin
            errors++;
            $display("FAIL load cyc=%0d got (%02h,%02h) expected (%02h,%02h) at cyc %0d",
                     cyc, dac_x, dac_y, e.pt[15:8], e.pt[7:0], e.cyc);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        errors++;
        $display("FAIL missed_ld cyc=%0d got no load expected (%02h,%02h)", cyc, e.pt[15:8], e.pt[7:0]);
      end
      if ({dac_x, dac_y} != m_cur || int'(count) != m_q.size() || full != (m_q.size() == 16) ||
          empty != (m_q.size() == 0) || overflow != m_ovf) begin
        errors++;
        $display("FAIL status cyc=%0d got xy=%02h%02h cnt=%0d full=%b empty=%b ovf=%b expected xy=%04h cnt=%0d full=%b empty=%b ovf=%b",
                 cyc, dac_x, dac_y, count, full, empty, overflow,
                 m_cur, m_q.size(), m_q.size() == 16, m_q.size() == 0, m_ovf);
      end
    end
  end

  initial begin
    wr = 0; xin = 0; yin = 0; dwell = 0; clr_ovf = 0; rst = 1;
    cyc = 0; en = 0; vectors = 0; errors = 0;
    m_left = 0; m_ovf = 0; m_cur = 16'h8080;

    // Reset state
    step(0, 0, 0, 0, 0, 1);
    en = 1;
    step(0, 0, 0, 0, 0, 1);

    // Single point, dwell 3
    step(1, 8'h10, 8'h20, 8'd3, 0, 0);
    idle(6, 8'd3);

    // Burst of 5, dwell 2
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 8'($urandom), 8'd2, 0, 0);
    idle(12, 8'd2);

    // Overflow: 20 back-to-back with long dwell, then clear semantics
    for (int i = 0; i < 20; i++) step(1, 8'($urandom), 8'($urandom), 8'd255, 0, 0);
    step(1, 8'hAA, 8'hBB, 8'd255, 1, 0);
    step(0, 8'h00, 8'h00, 8'd255, 1, 0);
    idle(3, 8'd255);
    step(0, 0, 0, 0, 0, 1);

    // dwell 0: one point per cycle
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 8'($urandom), 8'd0, 0, 0);
    idle(5, 8'd0);

    // Reset mid-hold with 8 buffered
    for (int i = 0; i < 9; i++) step(1, 8'($urandom), 8'($urandom), 8'd50, 0, 0);
    idle(2, 8'd50);
    step(0, 0, 0, 8'd50, 0, 1);
    idle(10, 8'd50);

    // Randomized traffic, including mid-hold dwell changes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 3) != 0, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 4)),
           ($urandom % 16) == 0, ($urandom % 600) == 0);
    end
    idle(120, 8'd1);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending loads expected 0", exp_q.size());
    end
    en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
